// File: rtl/riscv_multicycle.sv
// RV32I-subset multicycle core sharing one memory port for fetch and data.
// A single state machine sequences fetch, decode, execute, memory and writeback.
module riscv_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic             halted,
  output logic [CNT_W-1:0] instret,
  output logic [31:0]      pc_out
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXEC_R, EXEC_I, ALUWB, BEQ, JAL, HALT
  } state_t;

  state_t state, state_nx;

  logic [31:0] pc, old_pc, ir;
  logic [31:0] a, b, alu_out, data, target;
  logic [31:0] rf [32];
  logic        retire;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;
  logic [31:0] rf_a, rf_b;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7],
                  ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12],
                  ir[20], ir[30:21], 1'b0};

  assign rf_a = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rf_b = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

  logic alu_f3, is_lw, is_sw, is_r, is_i, is_beq, is_jal;

  assign alu_f3 = (f3 == 3'b000) || (f3 == 3'b111) ||
                  (f3 == 3'b110) || (f3 == 3'b010);
  assign is_lw  = (opcode == 7'h03) && (f3 == 3'b010);
  assign is_sw  = (opcode == 7'h23) && (f3 == 3'b010);
  assign is_r   = (opcode == 7'h33) && alu_f3;
  assign is_i   = (opcode == 7'h13) && alu_f3;
  assign is_beq = (opcode == 7'h63) && (f3 == 3'b000);
  assign is_jal = (opcode == 7'h6F);

  function automatic logic [31:0] alu(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [2:0]  f,
    input logic        sub
  );
    logic [31:0] r;
    r = '0;
    case (f)
      3'b000:  r = sub ? x - y : x + y;
      3'b111:  r = x & y;
      3'b110:  r = x | y;
      3'b010:  r = {31'd0, $signed(x) < $signed(y)};
      default: r = '0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc;
    mem_wdata = '0;
    retire    = 1'b0;
    unique case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) state_nx = DECODE;
      end
      DECODE: begin
        unique case (1'b1)
          is_lw, is_sw: state_nx = MEMADR;
          is_r:         state_nx = EXEC_R;
          is_i:         state_nx = EXEC_I;
          is_beq:       state_nx = BEQ;
          is_jal:       state_nx = JAL;
          default:      state_nx = HALT;
        endcase
      end
      MEMADR: state_nx = is_sw ? MEMWRITE : MEMREAD;
      MEMREAD: begin
        mem_req  = 1'b1;
        mem_addr = alu_out;
        if (mem_ready) state_nx = MEMWB;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = alu_out;
        mem_wdata = b;
        if (mem_ready) begin
          retire   = 1'b1;
          state_nx = FETCH;
        end
      end
      EXEC_R, EXEC_I: state_nx = ALUWB;
      MEMWB, ALUWB, BEQ, JAL: begin
        retire   = 1'b1;
        state_nx = FETCH;
      end
      HALT:    state_nx = HALT;
      default: state_nx = FETCH;
    endcase
    // Reset abandons any access in flight without waiting for ready.
    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = RESET_PC;
      mem_wdata = '0;
      retire    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      instret <= '0;
    end else begin
      if (retire) instret <= instret + 1'b1;
      if (state == FETCH && mem_ready) pc <= pc + 32'd4;
      if (state == BEQ && a == b)      pc <= target;
      if (state == JAL)                pc <= old_pc + imm_j;
    end
  end

  always_ff @(posedge clk) begin
    if (state == FETCH && mem_ready) begin
      ir     <= mem_rdata;
      old_pc <= pc;
    end
    if (state == DECODE) begin
      a      <= rf_a;
      b      <= rf_b;
      target <= old_pc + imm_b;
    end
    if (state == MEMADR)
      alu_out <= a + (is_sw ? imm_s : imm_i);
    if (state == EXEC_R)
      alu_out <= alu(a, b, f3, ir[30]);
    if (state == EXEC_I)
      alu_out <= alu(a, imm_i, f3, 1'b0);
    if (state == MEMREAD && mem_ready)
      data <= mem_rdata;
  end

  logic        rf_we;
  logic [31:0] rf_wd;

  always_comb begin
    rf_we = !rst && (rd != 5'd0) &&
            (state == MEMWB || state == ALUWB || state == JAL);
    rf_wd = alu_out;
    if (state == MEMWB) rf_wd = data;
    if (state == JAL)   rf_wd = old_pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rf_we) rf[rd] <= rf_wd;
  end

  assign halted = (state == HALT);
  assign pc_out = pc;

endmodule

// File: tb/tb_riscv_multicycle.sv
// Bench for riscv_multicycle: small programs run against a wait-state memory,
// stores checked through a scoreboard, retire counts and cycle counts checked.
module tb_riscv_multicycle;

  localparam logic [31:0] RPC = 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
  logic [31:0] instret;
  logic [31:0] mem [1024];

  int wait_n = 0;
  int wcnt   = 0;
  int total  = 0;
  int bad    = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;
  st_t sb[$];

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  riscv_multicycle #(.RESET_PC(RPC), .CNT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .halted    (halted),
    .instret   (instret),
    .pc_out    (pc_out)
  );

  always #5 clk = ~clk;

  // ready is also raised while idle so the core must ignore it then
  assign mem_ready = (wcnt >= wait_n);
  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk)
    wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : 0;

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  logic [65:0] held;
  logic        waiting = 1'b0;
  st_t         e;

  always @(negedge clk) begin
    if (!rst && waiting)
      chk("hold", {mem_req, mem_we, mem_addr, mem_wdata}, held);
    waiting = !rst && mem_req && !mem_ready;
    held    = {mem_req, mem_we, mem_addr, mem_wdata};
    if (!rst && mem_req && mem_ready && mem_we) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL store_unexpected: got addr %0h data %0h",
                 mem_addr, mem_wdata);
      end else begin
        e = sb.pop_front();
        chk("store_addr", mem_addr, e.addr);
        chk("store_data", mem_wdata, e.data);
      end
    end
  end

  function automatic logic [31:0] enc_r(
    input logic [6:0] f7, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(
    input logic [31:0] imm, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(
    input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(
    input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000,
            imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(
    input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    mem[addr[11:2]] = w;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, RPC);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_pc", pc_out, RPC);
    chk("rst_instret", instret, 0);
    chk("rst_halted", halted, 0);
    rst = 1'b0;
    #1;
    chk("fetch_req", mem_req, 1);
    chk("fetch_addr", mem_addr, RPC);
  endtask

  task automatic run_prog(input string nm, input int exp_cyc,
                          input int exp_first, input int exp_ret,
                          input logic [31:0] exp_pc);
    int cyc   = 0;
    int first = -1;
    do_reset();
    while (!halted && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (first < 0 && instret != 0) first = cyc;
      if (cyc == 1 && wait_n == 0)
        chk({nm, "_pc_after_fetch"}, pc_out, RPC + 32'd4);
    end
    chk({nm, "_halted"}, halted, 1);
    chk({nm, "_cycles"}, cyc, exp_cyc);
    chk({nm, "_first_retire"}, first, exp_first);
    chk({nm, "_instret"}, instret, exp_ret);
    chk({nm, "_pc"}, pc_out, exp_pc);
    repeat (4) begin
      @(negedge clk);
      chk({nm, "_halt_req"}, mem_req, 0);
    end
    chk({nm, "_halt_pc"}, pc_out, exp_pc);
    chk({nm, "_halt_instret"}, instret, exp_ret);
    chk({nm, "_sb_left"}, sb.size(), 0);
  endtask

  initial begin
    vec_t v[11];
    int   n;
    v[0]  = '{"add",  enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3),
              32'd5, 32'hFFD, 32'd2};
    v[1]  = '{"sub",  enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3),
              32'd5, 32'hFFD, 32'd8};
    v[2]  = '{"and",  enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd3),
              32'd12, 32'd10, 32'd8};
    v[3]  = '{"or",   enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd3),
              32'd12, 32'd10, 32'd14};
    v[4]  = '{"slt_t", enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3),
              32'hFFD, 32'd5, 32'd1};
    v[5]  = '{"slt_f", enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3),
              32'd5, 32'hFFD, 32'd0};
    v[6]  = '{"addi_neg", enc_i(32'hFFF, 5'd1, 3'b000, 5'd3, 7'h13),
              32'd0, 32'd0, 32'hFFFF_FFFF};
    v[7]  = '{"andi", enc_i(32'h0F0, 5'd1, 3'b111, 5'd3, 7'h13),
              32'h7FF, 32'd0, 32'h0F0};
    v[8]  = '{"ori",  enc_i(32'h800, 5'd1, 3'b110, 5'd3, 7'h13),
              32'd1, 32'd0, 32'hFFFF_F801};
    v[9]  = '{"slti", enc_i(32'hFFF, 5'd1, 3'b010, 5'd3, 7'h13),
              32'h800, 32'd0, 32'd1};
    v[10] = '{"addi_b30", enc_i(32'h400, 5'd1, 3'b000, 5'd3, 7'h13),
              32'd1, 32'd0, 32'h401};

    for (int i = 0; i < 11; i++) begin
      clear_mem();
      put(RPC,         enc_i(v[i].a, 5'd0, 3'b000, 5'd1, 7'h13));
      put(RPC + 32'd4, enc_i(v[i].b, 5'd0, 3'b000, 5'd2, 7'h13));
      put(RPC + 32'd8, v[i].instr);
      put(RPC + 32'd12, enc_s(32'h200, 5'd3, 5'd0));
      sb.push_back('{32'h200, v[i].exp});
      run_prog(v[i].name, 18, 4, 4, RPC + 32'h14);
    end

    clear_mem();
    put(32'h100, enc_i(32'd5,   5'd0, 3'b000, 5'd1, 7'h13));
    put(32'h104, enc_i(32'hFFD, 5'd0, 3'b000, 5'd2, 7'h13));
    put(32'h108, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3));
    put(32'h10C, enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd4));
    put(32'h110, enc_s(32'h0, 5'd3, 5'd0));
    put(32'h114, enc_s(32'h4, 5'd4, 5'd0));
    sb.push_back('{32'h0, 32'd2});
    sb.push_back('{32'h4, 32'd1});
    run_prog("alu_seq", 26, 4, 6, 32'h11C);

    clear_mem();
    wait_n = 3;
    put(32'h8,   32'hDEAD_BEEF);
    put(32'h100, enc_i(32'h8, 5'd0, 3'b010, 5'd5, 7'h03));
    put(32'h104, enc_s(32'h20, 5'd5, 5'd0));
    sb.push_back('{32'h20, 32'hDEAD_BEEF});
    run_prog("wait_lw", 26, 11, 2, 32'h10C);
    wait_n = 0;

    clear_mem();
    put(32'h100, enc_i(32'd7, 5'd0, 3'b000, 5'd6, 7'h13));
    put(32'h104, enc_b(32'd8, 5'd0, 5'd6));
    put(32'h108, enc_b(32'd8, 5'd0, 5'd0));
    put(32'h10C, enc_i(32'd1, 5'd0, 3'b000, 5'd6, 7'h13));
    put(32'h110, enc_j(32'd16, 5'd1));
    put(32'h114, enc_s(32'h40, 5'd1, 5'd0));
    put(32'h118, enc_s(32'h48, 5'd2, 5'd0));
    put(32'h120, enc_s(32'h44, 5'd6, 5'd0));
    put(32'h124, enc_j(32'hFFFF_FFF0, 5'd2));
    sb.push_back('{32'h44, 32'd7});
    sb.push_back('{32'h40, 32'h114});
    sb.push_back('{32'h48, 32'h128});
    run_prog("branch", 30, 4, 8, 32'h120);

    clear_mem();
    wait_n = 3;
    put(32'h8,   32'h1234_5678);
    put(32'h100, enc_i(32'd1, 5'd0, 3'b000, 5'd7, 7'h13));
    put(32'h104, enc_i(32'h8, 5'd0, 3'b010, 5'd5, 7'h03));
    do_reset();
    n = 0;
    while (!(mem_req && !mem_we && mem_addr == 32'h8) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mr_reached", mem_req && !mem_we && mem_addr == 32'h8, 1);
    chk("mr_instret", instret, 1);
    @(negedge clk);
    chk("mr_waiting", {mem_req, mem_ready}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_rst_req", mem_req, 0);
    chk("mr_rst_addr", mem_addr, RPC);
    chk("mr_rst_pc", pc_out, RPC);
    chk("mr_rst_instret", instret, 0);
    chk("mr_rst_halted", halted, 0);
    wait_n = 0;

    clear_mem();
    put(32'h100, enc_i(32'd9, 5'd0, 3'b000, 5'd0, 7'h13));
    put(32'h104, enc_s(32'h51, 5'd0, 5'd0));
    sb.push_back('{32'h51, 32'd0});
    run_prog("x0", 10, 4, 2, 32'h10C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
